// File: rtl/parking_counter_param.sv
// Purpose: car park occupancy tracker; two raw beam sensors are synchronised, debounced, and decoded
//          for direction, and a saturating count is kept.
// Latency: raw edge to debounced level takes 2+DEBOUNCE_CYCLES cycles. The event pulse is combinational
//          from the FSM, and count/full/empty/ovf/unf update one cycle after the event pulse.
// Backpressure: none; the inputs are free-running levels and the outputs are level/pulse indications.
// Ports: clk, rst (sync, active-high); sensor_a (outer) and sensor_b (inner) are raw asynchronous inputs;
//        count/full/empty give occupancy; entry/exit_pulse are direction events; ovf/unf_pulse are
//        saturation errors.
module parking_counter_param #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CAPACITY        = 7,
   parameter int WIDTH           = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_a,
   input  logic             sensor_b,
   output logic [WIDTH-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             entry_pulse,
   output logic             exit_pulse,
   output logic             ovf_pulse,
   output logic             unf_pulse
);

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] CAP     = WIDTH'(CAPACITY);

   typedef enum logic [2:0] {
      S_IDLE, S_A1, S_AB_IN, S_B_IN, S_B1, S_AB_OUT, S_A_OUT, S_WAIT_CLR
   } state_t;

   // Bit 1 carries sensor A and bit 0 carries sensor B, so r_deb reads directly as {a,b}.
   logic [1:0]     r_sync1;
   logic [1:0]     r_sync2;
   logic [1:0]     r_deb;
   logic [DBW-1:0] r_db_cnt [2];

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_entry_evt;
   logic           w_exit_evt;

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             r_ovf;
   logic             r_unf;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;

   // Synchroniser and debouncer for both sensors.
   // The debounce counter tracks consecutive disagreements and is cleared by any cycle of agreement.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= {sensor_a, sensor_b};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               // This is the DEBOUNCE_CYCLES-th consecutive disagreement, so the level flips now.
               r_deb[i]    <= ~r_deb[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Direction FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and Mealy event outputs. Events fire only on the return to (0,0),
   // so a held level can never repeat a pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_entry_evt = 1'b0;
      w_exit_evt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if      (r_deb == 2'b10) w_state_nxt = S_A1;
            else if (r_deb == 2'b01) w_state_nxt = S_B1;
            else if (r_deb == 2'b11) w_state_nxt = S_WAIT_CLR;
         end
         S_A1: begin
            if      (r_deb == 2'b11) w_state_nxt = S_AB_IN;
            else if (r_deb == 2'b00) w_state_nxt = S_IDLE;
            else if (r_deb == 2'b01) w_state_nxt = S_WAIT_CLR;
         end
         S_AB_IN: begin
            if      (r_deb == 2'b01) w_state_nxt = S_B_IN;
            else if (r_deb == 2'b10) w_state_nxt = S_A1;
            else if (r_deb == 2'b00) w_state_nxt = S_WAIT_CLR;
         end
         S_B_IN: begin
            if (r_deb == 2'b00) begin
               w_state_nxt = S_IDLE;
               w_entry_evt = 1'b1;
            end else if (r_deb == 2'b11) begin
               w_state_nxt = S_AB_IN;
            end else if (r_deb == 2'b10) begin
               w_state_nxt = S_WAIT_CLR;
            end
         end
         S_B1: begin
            if      (r_deb == 2'b11) w_state_nxt = S_AB_OUT;
            else if (r_deb == 2'b00) w_state_nxt = S_IDLE;
            else if (r_deb == 2'b10) w_state_nxt = S_WAIT_CLR;
         end
         S_AB_OUT: begin
            if      (r_deb == 2'b10) w_state_nxt = S_A_OUT;
            else if (r_deb == 2'b01) w_state_nxt = S_B1;
            else if (r_deb == 2'b00) w_state_nxt = S_WAIT_CLR;
         end
         S_A_OUT: begin
            if (r_deb == 2'b00) begin
               w_state_nxt = S_IDLE;
               w_exit_evt  = 1'b1;
            end else if (r_deb == 2'b11) begin
               w_state_nxt = S_AB_OUT;
            end else if (r_deb == 2'b01) begin
               w_state_nxt = S_WAIT_CLR;
            end
         end
         S_WAIT_CLR: begin
            if (r_deb == 2'b00) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Saturating count. full/empty are registered from the next count so all three always agree.
   always_comb begin
      w_count_nxt = r_count;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
      if (w_entry_evt) begin
         if (r_count == CAP) w_ovf_nxt = 1'b1;
         else                w_count_nxt = r_count + 1'b1;
      end else if (w_exit_evt) begin
         if (r_count == '0) w_unf_nxt = 1'b1;
         else               w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CAP);
         r_empty <= (w_count_nxt == '0);
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end
   end

   assign count       = r_count;
   assign full        = r_full;
   assign empty       = r_empty;
   assign entry_pulse = w_entry_evt & ~rst;
   assign exit_pulse  = w_exit_evt & ~rst;
   assign ovf_pulse   = r_ovf;
   assign unf_pulse   = r_unf;

endmodule

// File: tb/tb_parking_counter_param.sv
// Purpose: self-checking bench for parking_counter_param (DEBOUNCE_CYCLES=4, CAPACITY=3, WIDTH=2).
// Latency: every output is compared with a behavioural model one step after each rising edge.
// Backpressure: not applicable; the stimulus consists of raw sensor levels.
module tb_parking_counter_param;

   localparam int D   = 4;
   localparam int CAP = 3;
   localparam int W   = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sensor_a = 1'b0;
   logic         sensor_b = 1'b0;
   logic [W-1:0] count;
   logic         full, empty, entry_pulse, exit_pulse, ovf_pulse, unf_pulse;

   parking_counter_param #(.DEBOUNCE_CYCLES(D), .CAPACITY(CAP), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b),
      .count(count), .full(full), .empty(empty),
      .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
      .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_ent, n_ext, n_ovf, n_unf;

   // ---------------- behavioural reference model ----------------
   // The direction decoder is modelled as a position along a three-step level path:
   // the entry path is 10,11,01 and the exit path is 01,11,10.
   localparam int M_IDLE = -1, M_ENTRY = 0, M_EXIT = 1, M_WAIT = 2;
   logic [1:0] path [2][3];
   bit   q_a[$], q_b[$];          // the two-stage synchroniser, modelled as a delay line
   bit   m_deb_a, m_deb_b;
   int   m_run_a, m_run_b;        // length of the current run of disagreements
   int   m_dir, m_idx, m_cnt;
   bit   m_ent, m_ext, m_ovf, m_unf;

   task model_reset();
      q_a = {1'b0, 1'b0}; q_b = {1'b0, 1'b0};
      m_deb_a = 0; m_deb_b = 0; m_run_a = 0; m_run_b = 0;
      m_dir = M_IDLE; m_idx = 0; m_cnt = 0;
      m_ent = 0; m_ext = 0; m_ovf = 0; m_unf = 0;
   endtask

   task model_step(input bit a, input bit b, input bit r);
      logic [1:0] lvl;
      bit s_a, s_b;
      if (r) begin
         model_reset();
         return;
      end
      // The count consumes the event that was visible before this edge.
      m_ovf = 0; m_unf = 0;
      if (m_ent) begin if (m_cnt < CAP) m_cnt++; else m_ovf = 1; end
      if (m_ext) begin if (m_cnt > 0)   m_cnt--; else m_unf = 1; end
      // Direction tracking on the levels seen before the edge.
      lvl = {m_deb_a, m_deb_b};
      if (m_dir == M_IDLE) begin
         if      (lvl == path[M_ENTRY][0]) begin m_dir = M_ENTRY; m_idx = 0; end
         else if (lvl == path[M_EXIT][0])  begin m_dir = M_EXIT;  m_idx = 0; end
         else if (lvl != 2'b00)            m_dir = M_WAIT;
      end else if (m_dir == M_WAIT) begin
         if (lvl == 2'b00) m_dir = M_IDLE;
      end else begin
         if (lvl == path[m_dir][m_idx]) ;
         else if (m_idx < 2 && lvl == path[m_dir][m_idx+1]) m_idx++;
         else if (m_idx > 0 && lvl == path[m_dir][m_idx-1]) m_idx--;
         else if (lvl == 2'b00 && m_idx != 1)               m_dir = M_IDLE;
         else                                               m_dir = M_WAIT;
      end
      // Debounce: a level flips after D consecutive disagreeing synchronised samples.
      s_a = q_a.pop_front(); q_a.push_back(a);
      s_b = q_b.pop_front(); q_b.push_back(b);
      if (s_a != m_deb_a) m_run_a++; else m_run_a = 0;
      if (s_b != m_deb_b) m_run_b++; else m_run_b = 0;
      if (m_run_a == D) begin m_deb_a = ~m_deb_a; m_run_a = 0; end
      if (m_run_b == D) begin m_deb_b = ~m_deb_b; m_run_b = 0; end
      // An event is visible while the last path position is held and the levels are back at (0,0).
      lvl   = {m_deb_a, m_deb_b};
      m_ent = (m_dir == M_ENTRY && m_idx == 2 && lvl == 2'b00);
      m_ext = (m_dir == M_EXIT  && m_idx == 2 && lvl == 2'b00);
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task tick(input bit a, input bit b, input bit r);
      sensor_a = a; sensor_b = b; rst = r;
      @(posedge clk);
      model_step(a, b, r);
      #1;
      chk("count", int'(count), m_cnt);
      chk("full", int'(full), int'(m_cnt == CAP));
      chk("empty", int'(empty), int'(m_cnt == 0));
      chk("entry_pulse", int'(entry_pulse), int'(m_ent));
      chk("exit_pulse", int'(exit_pulse), int'(m_ext));
      chk("ovf_pulse", int'(ovf_pulse), int'(m_ovf));
      chk("unf_pulse", int'(unf_pulse), int'(m_unf));
      if (entry_pulse) n_ent++;
      if (exit_pulse)  n_ext++;
      if (ovf_pulse)   n_ovf++;
      if (unf_pulse)   n_unf++;
   endtask

   task hold(input bit a, input bit b, input int n);
      repeat (n) tick(a, b, 1'b0);
   endtask

   task do_reset();
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      n_ent = 0; n_ext = 0; n_ovf = 0; n_unf = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int kind;          // 0 = hold levels, 1 = glitch sensor A only
      bit a, b;
      int cyc;
      int cnt, ent, ext, ovf, unf;   // expected values at the end of the row
   } row_t;
   row_t tbl[$];

   task automatic add(input int kind, input bit a, input bit b, input int cyc,
                      input int c, input int e, input int x, input int o, input int u);
      row_t r;
      r.kind = kind; r.a = a; r.b = b; r.cyc = cyc;
      r.cnt = c; r.ent = e; r.ext = x; r.ovf = o; r.unf = u;
      tbl.push_back(r);
   endtask

   // A full crossing of 10 cycles per level; only the final (0,0) row changes the expectations.
   task automatic add_pass(input bit is_entry, input int c, input int e, input int x,
                           input int o, input int u);
      row_t p;
      p = tbl[tbl.size()-1];
      if (is_entry) begin
         add(0, 1, 0, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
         add(0, 1, 1, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
         add(0, 0, 1, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
      end else begin
         add(0, 0, 1, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
         add(0, 1, 1, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
         add(0, 1, 0, 10, p.cnt, p.ent, p.ext, p.ovf, p.unf);
      end
      add(0, 0, 0, 10, c, e, x, o, u);
   endtask

   task pass_seq(input bit is_entry, input int per);
      if (is_entry) begin hold(1,0,per); hold(1,1,per); hold(0,1,per); hold(0,0,per); end
      else          begin hold(0,1,per); hold(1,1,per); hold(1,0,per); hold(0,0,per); end
   endtask

   initial begin
      int lat;
      path[M_ENTRY][0] = 2'b10; path[M_ENTRY][1] = 2'b11; path[M_ENTRY][2] = 2'b01;
      path[M_EXIT][0]  = 2'b01; path[M_EXIT][1]  = 2'b11; path[M_EXIT][2]  = 2'b10;
      model_reset();

      add(0, 0, 0, 20, 0, 0, 0, 0, 0);
      add_pass(1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 30, 1, 1, 0, 0, 0);
      add_pass(0, 0, 1, 1, 0, 0);
      add_pass(1, 1, 2, 1, 0, 0);
      add_pass(1, 2, 3, 1, 0, 0);
      add_pass(1, 3, 4, 1, 0, 0);
      add_pass(1, 3, 5, 1, 1, 0);
      add_pass(0, 2, 5, 2, 1, 0);
      add_pass(0, 1, 5, 3, 1, 0);
      add_pass(0, 0, 5, 4, 1, 0);
      add_pass(0, 0, 5, 5, 1, 1);
      add(0, 1, 0, 10, 0, 5, 5, 1, 1);    // aborted entry
      add(0, 0, 0, 10, 0, 5, 5, 1, 1);
      add(0, 1, 1, 10, 0, 5, 5, 1, 1);    // both sensors together
      add(0, 0, 0, 10, 0, 5, 5, 1, 1);

      do_reset();
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_pulses", int'({entry_pulse, exit_pulse, ovf_pulse, unf_pulse}), 0);

      foreach (tbl[i]) begin
         if (tbl[i].kind == 1) begin
            int left;
            left = tbl[i].cyc;
            while (left > 0) begin
               int hi, lo;
               hi = $urandom_range(1, 3);
               lo = $urandom_range(1, 3);
               for (int k = 0; k < hi && left > 0; k++) begin tick(1, 0, 0); left--; end
               for (int k = 0; k < lo && left > 0; k++) begin tick(0, 0, 0); left--; end
            end
         end else begin
            hold(tbl[i].a, tbl[i].b, tbl[i].cyc);
         end
         chk($sformatf("row%0d_count", i), int'(count), tbl[i].cnt);
         chk($sformatf("row%0d_full", i), int'(full), int'(tbl[i].cnt == CAP));
         chk($sformatf("row%0d_empty", i), int'(empty), int'(tbl[i].cnt == 0));
         chk($sformatf("row%0d_entries", i), n_ent, tbl[i].ent);
         chk($sformatf("row%0d_exits", i), n_ext, tbl[i].ext);
         chk($sformatf("row%0d_ovf", i), n_ovf, tbl[i].ovf);
         chk($sformatf("row%0d_unf", i), n_unf, tbl[i].unf);
      end

      // Entry pulse latency measured from the B release; the count follows one cycle later.
      do_reset();
      hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         tick(0, 0, 0);
         if (entry_pulse) lat = k;
      end
      chk("entry_latency", lat, 6);
      chk("count_before_update", int'(count), 0);
      tick(0, 0, 0);
      chk("count_after_entry", int'(count), 1);
      chk("empty_after_entry", int'(empty), 0);

      // A reset while in AB_IN with two cars aborts the crossing.
      do_reset();
      pass_seq(1, 10); pass_seq(1, 10);
      hold(1, 0, 10); hold(1, 1, 10);
      chk("pre_rst_count", int'(count), 2);
      tick(1, 1, 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_empty", int'(empty), 1);
      n_ent = 0; n_ext = 0;
      hold(0, 1, 10); hold(0, 0, 10);
      chk("post_rst_entries", n_ent, 0);
      chk("post_rst_exits", n_ext, 0);
      chk("post_rst_count", int'(count), 0);

      // Randomised traffic: mixes structured crossings with random levels and occasional resets.
      do_reset();
      for (int s = 0; s < 300; s++) begin
         int pick;
         pick = $urandom_range(0, 99);
         if (pick < 2)        tick(0, 0, 1);
         else if (pick < 50)  pass_seq(pick[0], $urandom_range(5, 12));
         else                 hold($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                   $urandom_range(1, 12));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parking_counter_param.md
Name: parking_counter_param

Overview:
- Parametrised successor to the fixed 3-bit parking counter chain (debounce, direction FSM, up/down counter).
- Takes two raw beam sensors (A outer, B inner), debounces them, decodes car direction from the A/B overlap sequence, and keeps a saturating occupancy count.
- Reports full/empty status, one-cycle entry/exit event pulses and overflow/underflow error pulses.
- Sits between the board buttons/sensors and the LED/display logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=1).
- CAPACITY, 7, maximum occupancy (>=1).
- WIDTH, 3, count width; must satisfy 2^WIDTH-1 >= CAPACITY.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sensor_a  input  1  raw outer sensor, asynchronous, bouncy.
- sensor_b  input  1  raw inner sensor, asynchronous, bouncy.
- count  output  WIDTH  current occupancy.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- entry_pulse  output  1  one-cycle pulse on every completed entry sequence.
- exit_pulse  output  1  one-cycle pulse on every completed exit sequence.
- ovf_pulse  output  1  one-cycle pulse on an entry while full.
- unf_pulse  output  1  one-cycle pulse on an exit while empty.

Behaviour:
- Reset: count=0, empty=1, full=0, all pulses 0, FSM=IDLE, debounced levels=0, synchroniser and debounce counters cleared. A reset mid-sequence aborts the sequence with no count change.
- Input conditioning, per sensor:
  - 2-FF synchroniser feeds a debouncer.
  - The debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle of agreement clears the debounce counter.
  - Raw edge to debounced edge latency is 2+DEBOUNCE_CYCLES cycles.
- Direction FSM works on debounced levels (a,b) and has states IDLE, A1, AB_IN, B_IN, B1, AB_OUT, A_OUT, WAIT_CLR.
  - IDLE: (1,0)->A1; (0,1)->B1; (1,1)->WAIT_CLR.
  - A1: (1,1)->AB_IN; (0,0)->IDLE (abort); (0,1)->WAIT_CLR.
  - AB_IN: (0,1)->B_IN; (1,0)->A1 (backed out); (0,0)->WAIT_CLR.
  - B_IN: (0,0)->IDLE and assert entry_pulse; (1,1)->AB_IN; (1,0)->WAIT_CLR.
  - B1, AB_OUT, A_OUT are the mirror states (roles of a and b swapped). The A_OUT to IDLE transition on (0,0) asserts exit_pulse.
  - WAIT_CLR: stays until (0,0), then goes to IDLE with no event.
  - Holding a level keeps the current state.
- Counter:
  - Updates in the cycle after the event pulse; count/full/empty are registered and stay consistent in every cycle.
  - Entry with count<CAPACITY: count+1. Entry with count==CAPACITY: count holds, ovf_pulse is asserted in the cycle after entry_pulse.
  - Exit with count>0: count-1. Exit with count==0: count holds, unf_pulse is asserted in the cycle after exit_pulse.
  - No wrap-around in either direction.
  - Entry and exit cannot be pulsed in the same cycle (single FSM).
- The FSM only produces pulses after a level change, so no pulse is ever repeated while a sensor is held.

Test Plan (DEBOUNCE_CYCLES=4, CAPACITY=3, WIDTH=2):
- Reset, then drive idle inputs for 20 cycles -> count=0, empty=1, full=0, no pulses.
- Clean entry (A; A+B; B; none, each held 10 cycles) -> exactly one entry_pulse, 6 cycles after the final B fall; count=1 one cycle later; empty=0.
- Bounce A with 1-3 cycle glitches for 30 cycles, then do a clean exit -> no state change from glitches; one exit_pulse; count returns to 0.
- Four entries from 0 -> count 1,2,3,3; full=1 after the third entry; ovf_pulse on the fourth only. Then one exit -> count=2, full=0.
- Exit from empty -> unf_pulse, count stays 0. Aborted entry (A, then none) -> no pulse. Both sensors rising together -> WAIT_CLR, no pulse.
- Assert rst while in AB_IN with count=2 -> count=0 the next cycle; releasing the sensors afterwards produces no pulse.
